// File: rtl/video_timing_gen.sv
// Raster timing generator with a divided pixel enable and a small set of test patterns.
// Every output except ce_pix updates on the pixel enable, decoded from the pre-increment counters.
module video_timing_gen #(
    parameter int unsigned CE_DIV   = 4,
    parameter int unsigned H_ACTIVE = 256,
    parameter int unsigned H_FP     = 8,
    parameter int unsigned H_SYNC   = 32,
    parameter int unsigned H_BP     = 46,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 16
) (
    input  logic       clk_vid,
    input  logic       reset,
    input  logic [1:0] pattern,
    output logic       ce_pix,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       HSync,
    output logic       VSync,
    output logic       HBlank,
    output logic       VBlank,
    output logic [9:0] hcount,
    output logic [8:0] vcount,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam int unsigned HW      = 10;
    localparam int unsigned VW      = 9;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
    localparam logic [HW-1:0]    H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0]    H_SS     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]    H_SE     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0]    H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]    V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0]    V_SS     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]    V_SE     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0]    V_LAST   = VW'(V_TOTAL - 1);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic [HW-1:0]    hc;
    logic [VW-1:0]    vc;
    logic [1:0]       pat_q;
    logic [1:0]       pat_c;
    logic             first_c;
    logic             hblank_c;
    logic             vblank_c;
    logic             hsync_c;
    logic             vsync_c;
    logic [7:0]       r_c;
    logic [7:0]       g_c;
    logic [7:0]       b_c;

    // Decode of the current counter position; the first pixel of a frame already uses the new pattern.
    always_comb begin
        div_nxt  = (div == DIV_LAST) ? '0 : div + 1'b1;
        first_c  = (hc == '0) && (vc == '0);
        pat_c    = first_c ? pattern : pat_q;
        hblank_c = (hc >= H_ACT);
        vblank_c = (vc >= V_ACT);
        hsync_c  = (hc >= H_SS) && (hc < H_SE);
        vsync_c  = (vc >= V_SS) && (vc < V_SE);
        r_c      = '0;
        g_c      = '0;
        b_c      = '0;
        if (!hblank_c && !vblank_c) begin
            case (pat_c)
                2'd0: begin
                    r_c = {8{hc[7]}};
                    g_c = {8{hc[6]}};
                    b_c = {8{hc[5]}};
                end
                2'd1: begin
                    if ((hc[3:0] == 4'd0) || (vc[3:0] == 4'd0)) begin
                        r_c = 8'hFF;
                        g_c = 8'hFF;
                        b_c = 8'hFF;
                    end
                end
                2'd2: begin
                    r_c = 8'hFF;
                    g_c = 8'hFF;
                    b_c = 8'hFF;
                end
                default: begin
                    r_c = hc[7:0];
                    g_c = hc[7:0];
                    b_c = hc[7:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk_vid) begin
        if (reset) begin
            div         <= '0;
            ce_pix      <= 1'b0;
            hc          <= '0;
            vc          <= '0;
            pat_q       <= '0;
            R           <= '0;
            G           <= '0;
            B           <= '0;
            HSync       <= 1'b0;
            VSync       <= 1'b0;
            HBlank      <= 1'b0;
            VBlank      <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            frame_start <= 1'b0;
        end else begin
            div    <= div_nxt;
            ce_pix <= (div_nxt == DIV_LAST);
            if (ce_pix) begin
                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
                end else begin
                    hc <= hc + 1'b1;
                end
                if (first_c) begin
                    pat_q <= pattern;
                end
                R           <= r_c;
                G           <= g_c;
                B           <= b_c;
                HSync       <= hsync_c;
                VSync       <= vsync_c;
                HBlank      <= hblank_c;
                VBlank      <= vblank_c;
                hcount      <= hc;
                vcount      <= vc;
                frame_start <= first_c;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: default horizontal timing, shortened vertical timing (8 lines per frame).
module tb_video_timing_gen;

    localparam int unsigned H_TOTAL  = 342;
    localparam int unsigned V_ACTIVE = 4;
    localparam int unsigned V_FP     = 1;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 1;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int          F        = H_TOTAL * V_TOTAL;

    logic       clk_vid = 1'b0;
    logic       reset   = 1'b1;
    logic [1:0] pattern = 2'd0;
    logic       ce_pix;
    logic [7:0] R, G, B;
    logic       HSync, VSync, HBlank, VBlank;
    logic [9:0] hcount;
    logic [8:0] vcount;
    logic       frame_start;

    video_timing_gen #(
        .CE_DIV(4), .H_ACTIVE(256), .H_FP(8), .H_SYNC(32), .H_BP(46),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk_vid(clk_vid), .reset(reset), .pattern(pattern), .ce_pix(ce_pix),
        .R(R), .G(G), .B(B), .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
        .hcount(hcount), .vcount(vcount), .frame_start(frame_start)
    );

    initial forever #5 clk_vid = ~clk_vid;

    typedef struct {
        int          idx;
        logic [23:0] rgb;
        logic        hs, vs, hb, vb, fs;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   ev = 0;
    logic rst_s = 1'b1;
    logic ce_q = 1'b0;
    int   hb_l0 = 0, hs_l0 = 0, vb_f0 = 0, vs_f0 = 0, lines_f0 = 0, fs_cnt = 0;

    function automatic void push(int idx, logic [23:0] rgb, logic hs, logic vs, logic hb, logic vb, logic fs);
        exp_t e;
        e.idx = idx; e.rgb = rgb; e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb; e.fs = fs;
        exp_q.push_back(e);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ev(input int target);
        int n = 0;
        int budget = (target - ev) * 4 + 64;
        while (ev < target && n < budget) begin
            @(negedge clk_vid);
            n++;
        end
        if (ev < target) begin
            checks++;
            failures++;
            $display("FAIL wait_ev: reached %0d pixel updates, expected %0d", ev, target);
        end
    endtask

    // Reset as the DUT saw it at the most recent rising edge.
    initial forever begin
        @(posedge clk_vid);
        rst_s = reset;
    end

    // Monitor: an output update is present after every edge that closed a ce_pix cycle.
    initial begin : monitor
        exp_t        e;
        logic [47:0] exp_v, act_v;
        forever begin
            @(negedge clk_vid);
            if (rst_s) begin
                ev   = 0;
                ce_q = 1'b0;
            end else begin
                if (ce_q) begin
                    if (ev < H_TOTAL) begin
                        hb_l0 += int'(HBlank);
                        hs_l0 += int'(HSync);
                    end
                    if (ev < F) begin
                        vb_f0    += int'(VBlank);
                        vs_f0    += int'(VSync);
                        lines_f0 += int'(hcount == 10'd0);
                    end
                    if (ev < 2 * F) fs_cnt += int'(frame_start);
                    while (exp_q.size() > 0 && exp_q[0].idx <= ev) begin
                        e = exp_q.pop_front();
                        checks++;
                        exp_v = {10'(e.idx % H_TOTAL), 9'((e.idx / H_TOTAL) % V_TOTAL), e.rgb,
                                 e.hs, e.vs, e.hb, e.vb, e.fs};
                        act_v = {hcount, vcount, R, G, B, HSync, VSync, HBlank, VBlank, frame_start};
                        if (e.idx != ev || act_v !== exp_v) begin
                            failures++;
                            $display("FAIL pixel %0d (update %0d): got h=%0d v=%0d rgb=%02h%02h%02h hs,vs,hb,vb,fs=%b%b%b%b%b expected h=%0d v=%0d rgb=%06h hs,vs,hb,vb,fs=%b%b%b%b%b",
                                     e.idx, ev, hcount, vcount, R, G, B, HSync, VSync, HBlank, VBlank, frame_start,
                                     exp_v[47:38], exp_v[37:29], e.rgb, e.hs, e.vs, e.hb, e.vb, e.fs);
                        end
                    end
                    ev++;
                end
                ce_q = ce_pix;
            end
        end
    end

    initial begin : stimulus
        int n;
        reset   = 1'b1;
        pattern = 2'd0;
        repeat (3) @(negedge clk_vid);
        check("reset_outputs", {ce_pix, R, G, B, HSync, VSync, HBlank, VBlank, hcount, vcount, frame_start}, 64'd0);

        // Frame 0: colour bars, pattern switched to white on line 2 (must not show until frame 1).
        push(0,    24'h000000, 0, 0, 0, 0, 1);
        push(32,   24'h0000FF, 0, 0, 0, 0, 0);
        push(96,   24'h00FFFF, 0, 0, 0, 0, 0);
        push(160,  24'hFF00FF, 0, 0, 0, 0, 0);
        push(224,  24'hFFFFFF, 0, 0, 0, 0, 0);
        push(255,  24'hFFFFFF, 0, 0, 0, 0, 0);
        push(256,  24'h000000, 0, 0, 1, 0, 0);
        push(263,  24'h000000, 0, 0, 1, 0, 0);
        push(264,  24'h000000, 1, 0, 1, 0, 0);
        push(295,  24'h000000, 1, 0, 1, 0, 0);
        push(296,  24'h000000, 0, 0, 1, 0, 0);
        push(341,  24'h000000, 0, 0, 1, 0, 0);
        push(342,  24'h000000, 0, 0, 0, 0, 0);
        push(1058, 24'h0000FF, 0, 0, 0, 0, 0);
        push(1367, 24'h000000, 0, 0, 1, 0, 0);
        push(1368, 24'h000000, 0, 0, 0, 1, 0);
        push(1709, 24'h000000, 0, 0, 1, 1, 0);
        push(1710, 24'h000000, 0, 1, 0, 1, 0);
        push(2393, 24'h000000, 0, 1, 1, 1, 0);
        push(2394, 24'h000000, 0, 0, 0, 1, 0);
        push(2494, 24'h000000, 0, 0, 0, 1, 0);
        push(2735, 24'h000000, 0, 0, 1, 1, 0);
        // Frame 1: solid white.
        push(2736, 24'hFFFFFF, 0, 0, 0, 0, 1);
        push(2836, 24'hFFFFFF, 0, 0, 0, 0, 0);
        push(3006, 24'h000000, 1, 0, 1, 0, 0);
        push(3083, 24'hFFFFFF, 0, 0, 0, 0, 0);
        // Frame 2: grid.
        push(5472, 24'hFFFFFF, 0, 0, 0, 0, 1);
        push(5477, 24'hFFFFFF, 0, 0, 0, 0, 0);
        push(5814, 24'hFFFFFF, 0, 0, 0, 0, 0);
        push(5830, 24'hFFFFFF, 0, 0, 0, 0, 0);
        push(5831, 24'h000000, 0, 0, 0, 0, 0);
        push(6069, 24'h000000, 0, 0, 0, 0, 0);
        push(6856, 24'h000000, 0, 0, 0, 1, 0);
        // Frame 3: ramp.
        push(8208, 24'h000000, 0, 0, 0, 0, 1);
        push(8285, 24'h4D4D4D, 0, 0, 0, 0, 0);
        push(8463, 24'hFFFFFF, 0, 0, 0, 0, 0);
        push(8464, 24'h000000, 0, 0, 1, 0, 0);
        push(8750, 24'hC8C8C8, 0, 0, 0, 0, 0);

        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_vid);
            check($sformatf("ce_cadence_%0d", k), 64'(ce_pix), 64'((k % 4) == 3));
        end

        wait_ev(700);
        pattern = 2'd2;
        wait_ev(F);
        check("hblank_per_line", 64'(hb_l0), 64'd86);
        check("hsync_per_line", 64'(hs_l0), 64'd32);
        check("vblank_per_frame", 64'(vb_f0), 64'(4 * 342));
        check("vsync_per_frame", 64'(vs_f0), 64'(2 * 342));
        check("lines_per_frame", 64'(lines_f0), 64'd8);
        wait_ev(F + 700);
        pattern = 2'd1;
        wait_ev(2 * F);
        check("frame_start_pulses", 64'(fs_cnt), 64'd2);
        wait_ev(2 * F + 700);
        pattern = 2'd3;

        // Mid-frame reset at line 2, pixel 77 of frame 3.
        wait_ev(3 * F + 2 * 342 + 78);
        check("queue_empty_before_reset", 64'(exp_q.size()), 64'd0);
        reset = 1'b1;
        @(negedge clk_vid);
        check("reset_mid_frame_outputs",
              {ce_pix, R, G, B, HSync, VSync, HBlank, VBlank, hcount, vcount, frame_start}, 64'd0);
        push(0, 24'h000000, 0, 0, 0, 0, 1);
        push(1, 24'h010101, 0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_vid);
            check($sformatf("ce_after_reset_%0d", k), 64'(ce_pix), 64'((k % 4) == 3));
        end
        wait_ev(3);

        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk_vid);
            n++;
        end
        check("expected_all_consumed", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
